// File: rtl/hvac_output_sequencer.sv
// HVAC actuator sequencer: minimum run time, post-run lockout and heat/cool exclusion.
// Optional macro FAN_RUNON_EN keeps the fan running through LOCKOUT.
module hvac_output_sequencer #(
    parameter int MIN_ON_CYCLES  = 16,
    parameter int LOCKOUT_CYCLES = 32,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       heat_req,
    input  logic       cool_req,
    output logic       heater_on,
    output logic       cooler_on,
    output logic       fan_on,
    output logic       conflict,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEAT    = 2'd1,
        COOL    = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] MIN_TERM  = CNT_W'(MIN_ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_TERM = CNT_W'(LOCKOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             conflict_q, conflict_d;
    logic             min_met, lock_done;
    logic [CNT_W-1:0] term;

    assign min_met   = (cnt_q == MIN_TERM);
    assign lock_done = (cnt_q == LOCK_TERM);

    always_comb begin
        state_d    = state_q;
        conflict_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (heat_req && !cool_req)      state_d = HEAT;
                else if (cool_req && !heat_req) state_d = COOL;
                conflict_d = heat_req && cool_req;
            end
            // An early request drop is ignored until the minimum run is met.
            HEAT:    if (min_met && (!heat_req || cool_req)) state_d = LOCKOUT;
            COOL:    if (min_met && (!cool_req || heat_req)) state_d = LOCKOUT;
            LOCKOUT: if (lock_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counter restarts on every state change and saturates so a held request never wraps it.
    always_comb begin
        term  = (state_q == LOCKOUT) ? LOCK_TERM : MIN_TERM;
        cnt_d = cnt_q;
        if (state_d != state_q || state_q == IDLE) cnt_d = '0;
        else if (cnt_q != term)                    cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            conflict_q <= conflict_d;
        end
    end

    assign heater_on = (state_q == HEAT);
    assign cooler_on = (state_q == COOL);
    assign conflict  = conflict_q;
    assign state     = state_q;
`ifdef FAN_RUNON_EN
    assign fan_on    = (state_q == HEAT) || (state_q == COOL) || (state_q == LOCKOUT);
`else
    assign fan_on    = (state_q == HEAT) || (state_q == COOL);
`endif

endmodule

// File: tb/tb_hvac_output_sequencer.sv
// Bench for hvac_output_sequencer: time-in-mode reference model plus directed literal checks.
module tb_hvac_output_sequencer;

    localparam int MIN_ON = 4;
    localparam int LOCK   = 3;

    logic       clk = 0;
    logic       rst = 0;
    logic       heat_req = 0, cool_req = 0, heat2 = 0;
    logic       heater_on, cooler_on, fan_on, conflict;
    logic [1:0] state;
    logic       heater2, cooler2, fan2, conflict2;
    logic [1:0] state2;

    int checks = 0;
    int fails  = 0;

    hvac_output_sequencer #(.MIN_ON_CYCLES(MIN_ON), .LOCKOUT_CYCLES(LOCK), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .heat_req(heat_req), .cool_req(cool_req),
        .heater_on(heater_on), .cooler_on(cooler_on), .fan_on(fan_on),
        .conflict(conflict), .state(state)
    );

    hvac_output_sequencer #(.MIN_ON_CYCLES(2), .LOCKOUT_CYCLES(3), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .heat_req(heat2), .cool_req(1'b0),
        .heater_on(heater2), .cooler_on(cooler2), .fan_on(fan2),
        .conflict(conflict2), .state(state2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode plus number of cycles already spent in that mode.
    int m_mode = 0;
    int m_age  = 0;
    int m_conf = 0;

    function automatic int next_mode(input int mode, input int age, input logic h, input logic c);
        case (mode)
            0: return (h && !c) ? 1 : (c && !h) ? 2 : 0;
            1: return (age + 1 >= MIN_ON && (!h || c)) ? 3 : 1;
            2: return (age + 1 >= MIN_ON && (!c || h)) ? 3 : 2;
            default: return (age + 1 >= LOCK) ? 0 : 3;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode <= 0;
            m_age  <= 0;
            m_conf <= 0;
        end else begin
            m_mode <= next_mode(m_mode, m_age, heat_req, cool_req);
            m_age  <= (next_mode(m_mode, m_age, heat_req, cool_req) == m_mode) ? m_age + 1 : 0;
            m_conf <= (m_mode == 0 && heat_req && cool_req) ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("state", state, m_mode);
            chk("heater_on", heater_on, (m_mode == 1) ? 1 : 0);
            chk("cooler_on", cooler_on, (m_mode == 2) ? 1 : 0);
`ifdef FAN_RUNON_EN
            chk("fan_on", fan_on, (m_mode != 0) ? 1 : 0);
`else
            chk("fan_on", fan_on, (m_mode == 1 || m_mode == 2) ? 1 : 0);
`endif
            chk("conflict", conflict, m_conf);
            chk("exclusive", heater_on & cooler_on, 0);
        end
    end

    int exp_pulse_state[8] = '{1, 1, 1, 1, 3, 3, 3, 0};
`ifdef FAN_RUNON_EN
    int exp_pulse_fan[8]   = '{1, 1, 1, 1, 1, 1, 1, 0};
`else
    int exp_pulse_fan[8]   = '{1, 1, 1, 1, 0, 0, 0, 0};
`endif
    int exp_sat_tail[4]    = '{3, 3, 3, 0};

    initial begin
        int n;
        int first;

        // Reset takes effect before any clock edge.
        #1 rst = 1;
        #1;
        chk("rst_state", state, 0);
        chk("rst_heater", heater_on, 0);
        chk("rst_cooler", cooler_on, 0);
        chk("rst_fan", fan_on, 0);
        chk("rst_conflict", conflict, 0);
        repeat (2) @(negedge clk);
        rst = 0;

        // Single-cycle heat pulse still gets a full minimum run and lockout.
        @(negedge clk); heat_req = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) heat_req = 0;
            chk("pulse_state", state, exp_pulse_state[i]);
            chk("pulse_fan", fan_on, exp_pulse_fan[i]);
        end

        // Held cool for 10 samples.
        cool_req = 1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cooler_on) n++;
            if (i == 9)  cool_req = 0;
            if (i == 12) chk("cool_lockout", state, 3);
            if (i == 13) chk("cool_idle", state, 0);
        end
        chk("cool_len", n, 10);

        // Both requests in IDLE: conflict pulses, no actuator; then heat alone wins.
        heat_req = 1; cool_req = 1;
        n = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (conflict) n++;
            chk("conf_idle", state, 0);
        end
        chk("conf_len", n, 2);
        cool_req = 0;
        @(negedge clk);
        chk("conf_to_heat", state, 1);
        chk("conf_clear", conflict, 0);
        heat_req = 0;
        repeat (10) @(negedge clk);

        // Reversal: heat then cool must pass through lockout and an IDLE cycle.
        heat_req = 1;
        first = -1;
        n = 0;
        for (int t = 1; t <= 14; t++) begin
            @(negedge clk);
            if (t == 1) heat_req = 0;
            if (t == 2) cool_req = 1;
            if (heater_on) n++;
            if (cooler_on && first < 0) first = t;
        end
        chk("rev_heat_len", n, 4);
        chk("rev_cool_start", first, 9);
        cool_req = 0;
        repeat (20) @(negedge clk);

        // Asynchronous reset in the middle of a heat run.
        heat_req = 1;
        repeat (2) @(negedge clk);
        #2 rst = 1;
        #1;
        chk("arst_state", state, 0);
        chk("arst_heater", heater_on, 0);
        chk("arst_fan", fan_on, 0);
        chk("arst_conflict", conflict, 0);
        heat_req = 0;
        @(negedge clk); rst = 0;
        repeat (3) begin
            @(negedge clk);
            chk("arst_stay_idle", state, 0);
        end

        // Randomized requests with some persistence.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                heat_req = 1'($urandom_range(0, 1));
                cool_req = 1'($urandom_range(0, 1));
            end
        end
        heat_req = 0; cool_req = 0;
        repeat (20) @(negedge clk);

        // Narrow counter: a long held request must not wrap the counter.
        heat2 = 1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (heater2) n++;
        end
        chk("sat_len", n, 100);
        heat2 = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("sat_tail", state2, exp_sat_tail[i]);
        end
        chk("sat_conflict", conflict2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/hvac_output_sequencer.md
Name: hvac_output_sequencer

Overview:
- Sits directly downstream of the temperature comparator; consumes its heat request (`red`) and cool request (`blue`).
- Produces protected actuator enables for the heater, cooler and fan.
- Enforces a minimum run time, a post-run lockout, and mutual exclusion, so comparator chatter near the set point cannot short-cycle the equipment.

Parameters:
- MIN_ON_CYCLES, 16, minimum number of cycles `heater_on` or `cooler_on` stays high once asserted; must be ≥1.
- LOCKOUT_CYCLES, 32, number of cycles both actuators are forced off after any run; must be ≥1.
- CNT_W, 16, width of the shared phase counter; both cycle parameters must be < 2^CNT_W.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- heat_req  input  1  heat request, driven from the comparator `red` output; synchronous to clk.
- cool_req  input  1  cool request, driven from the comparator `blue` output; synchronous to clk.
- heater_on  output  1  heater enable, registered.
- cooler_on  output  1  cooler enable, registered.
- fan_on  output  1  fan enable, registered.
- conflict  output  1  one-cycle pulse, registered: both requests were high while IDLE.
- state  output  2  current state encoding, for debug and LEDs.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: while rst is high, state=IDLE, counter=0, and heater_on, cooler_on, fan_on and conflict are all 0. These take effect immediately, with no clock edge needed. Reset mid-run aborts the run with no lockout; after release the block starts in IDLE.
- State encoding: IDLE=0, HEAT=1, COOL=2, LOCKOUT=3.
- Outputs: all outputs are decoded from the registered state and counter.
  - heater_on = (state==HEAT)
  - cooler_on = (state==COOL)
  - heater_on and cooler_on are never both 1.
- Latency: a request sampled at edge k gives the actuator enable high after edge k+1 (one-cycle latency).
- Counter: cleared to 0 on every state change. Otherwise it increments each cycle and saturates at its terminal value.
  - In HEAT/COOL, the terminal value is MIN_ON_CYCLES-1; min_met = (cnt == MIN_ON_CYCLES-1).
  - In LOCKOUT, the terminal value is LOCKOUT_CYCLES-1; lock_done = (cnt == LOCKOUT_CYCLES-1).
- Transitions from IDLE:
  - heat_req & !cool_req → HEAT.
  - cool_req & !heat_req → COOL.
  - heat_req & cool_req → stay in IDLE; conflict=1 for the next cycle only.
  - Neither request → stay in IDLE.
- Transitions from HEAT:
  - min_met & (!heat_req | cool_req) → LOCKOUT.
  - Otherwise stay in HEAT.
  - A heat_req drop before min_met is ignored.
- Transitions from COOL:
  - min_met & (!cool_req | heat_req) → LOCKOUT.
  - Otherwise stay in COOL.
- Transitions from LOCKOUT:
  - lock_done → IDLE.
  - All requests are ignored during LOCKOUT.
- Resulting timing:
  - Minimum actuator-high time is exactly MIN_ON_CYCLES.
  - LOCKOUT lasts exactly LOCKOUT_CYCLES.
  - At least one IDLE cycle always separates LOCKOUT from the next run.
  - A direct HEAT↔COOL switch is impossible.
- Held request: a continuously held request keeps the actuator on indefinitely; the counter stays saturated and does not wrap.
- conflict is never asserted outside IDLE.

Optional Feature:
- Macro: FAN_RUNON_EN.
- Defined: fan_on = (state==HEAT) | (state==COOL) | (state==LOCKOUT). The fan runs on through the lockout to purge the coil.
- Undefined: fan_on = (state==HEAT) | (state==COOL). The fan drops together with the actuator.

Test Plan (MIN_ON_CYCLES=4, LOCKOUT_CYCLES=3 unless stated):
- Reset: assert rst mid-HEAT between clock edges → heater_on, fan_on and conflict go to 0 and state to 0 without any clk edge. Release rst with heat_req=0 → block stays IDLE.
- Heat pulse: heat_req=1 for one cycle, sampled at edge 0.
  - heater_on high after edges 1–4 (4 cycles), then state=3 for 3 cycles, then state=0.
  - fan_on high for 4 cycles without FAN_RUNON_EN, 7 cycles with it.
- Held cool: cool_req=1 for 10 cycles from edge 0 → cooler_on high for exactly 10 cycles (edges 1–10), then LOCKOUT for 3 cycles, then IDLE.
- Reversal: heat_req high at edge 0, dropped at edge 1; cool_req high from edge 2 onward.
  - heater_on high for 4 cycles, then LOCKOUT for 3 cycles, then 1 IDLE cycle, then cooler_on.
  - heater_on and cooler_on never overlap.
- Conflict: heat_req=cool_req=1 in IDLE for 2 cycles → conflict high for 2 cycles, state stays 0, no actuator asserted. Drop cool_req → HEAT on the next edge.
- Saturation: MIN_ON_CYCLES=2, CNT_W=2, heat_req held for 100 cycles → heater_on stays high for all 100 cycles; counter stays at 1 and does not wrap.
